cursor_ctrl: RTL and testbench

- Input stage directly upstream of Play.
- Turns five raw board buttons (up/down/left/right/select) into the cursor_x, cursor_y and is_pressed signals that Play consumes.
- Each button is synchronised, debounced and edge-detected. Cursor moves on an 8x8 board with wrap-around; select gives a single-cycle press pulse. All input is frozen once Play reports game_over.

---
 rtl/chess_pkg.sv | 35 +++
 rtl/btn_debounce.sv | 54 +++++
 rtl/cursor_ctrl.sv | 123 ++++++++++++
 tb/tb_cursor_ctrl.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared constants for the chess input path: board geometry, coordinate
// width, the bit position of each board button, and the wrap-around
// stepping rule used by the cursor.
package chess_pkg;

  localparam int BOARD_SIZE = 8;
  localparam int COORD_W    = 4;
  localparam int NUM_BTNS   = 5;
  localparam int NUM_DIRS   = 4;

  localparam int BTN_UP    = 0;
  localparam int BTN_DOWN  = 1;
  localparam int BTN_LEFT  = 2;
  localparam int BTN_RIGHT = 3;
  localparam int BTN_SEL   = 4;

  // One step along an axis with wrap-around. Opposing requests in the same
  // cycle cancel, so the coordinate only moves when exactly one is active.
  function automatic logic [COORD_W-1:0] stepCoord(
    input logic [COORD_W-1:0] coord,
    input logic               dec,
    input logic               inc,
    input int                 size
  );
    logic [COORD_W-1:0] maxCoord;
    maxCoord  = COORD_W'(size - 1);
    stepCoord = coord;
    if (dec && !inc) begin
      stepCoord = (coord == '0) ? maxCoord : coord - 1'b1;
    end else if (inc && !dec) begin
      stepCoord = (coord == maxCoord) ? '0 : coord + 1'b1;
    end
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button lane: two-flop synchroniser for the raw asynchronous input,
// a stable-level debouncer, and a rising-edge detector on the accepted
// level. The level only flips after DEBOUNCE_CYCLES consecutive samples
// that disagree with it; any agreeing sample restarts the count.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_stableDly;
  logic [CNT_W-1:0] r_count;

  // Synchronise, count disagreeing samples, and accept the new level once
  // the run of disagreement is long enough; the delayed copy feeds the
  // edge detector.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_stable    <= 1'b0;
      r_stableDly <= 1'b0;
      r_count     <= '0;
    end else begin
      r_sync1     <= i_btn;
      r_sync2     <= r_sync1;
      r_stableDly <= r_stable;
      if (r_sync2 != r_stable) begin
        if (r_count == CNT_LAST) begin
          r_stable <= r_sync2;
          r_count  <= '0;
        end else begin
          r_count <= r_count + 1'b1;
        end
      end else begin
        r_count <= '0;
      end
    end
  end

  assign o_level = r_stable;
  assign o_rise  = r_stable & ~r_stableDly;

endmodule

// File: rtl/cursor_ctrl.sv
// Board input stage: five debounced buttons drive an 8x8 wrap-around
// cursor and a one-cycle select pulse for the game logic. Everything is
// frozen while game_over is high, but the debouncers keep tracking the
// buttons so a button held across game_over needs a fresh press.
// Optional build macro CURSOR_AUTOREPEAT_EN adds hold-to-repeat on the
// four direction buttons.
module cursor_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int BOARD_SIZE      = chess_pkg::BOARD_SIZE,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 15000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          btn_up,
  input  logic                          btn_down,
  input  logic                          btn_left,
  input  logic                          btn_right,
  input  logic                          btn_sel,
  input  logic                          game_over,
  output logic [chess_pkg::COORD_W-1:0] cursor_x,
  output logic [chess_pkg::COORD_W-1:0] cursor_y,
  output logic                          is_pressed
);

  import chess_pkg::*;

  logic [NUM_BTNS-1:0] w_raw;
  logic [NUM_BTNS-1:0] w_level;
  logic [NUM_BTNS-1:0] w_rise;
  logic [NUM_DIRS-1:0] w_repeat;
  logic [NUM_DIRS-1:0] w_move;
  logic [COORD_W-1:0]  w_nextX;
  logic [COORD_W-1:0]  w_nextY;
  logic                w_nextPressed;
  logic [COORD_W-1:0]  r_x;
  logic [COORD_W-1:0]  r_y;
  logic                r_pressed;

  assign w_raw[BTN_UP]    = btn_up;
  assign w_raw[BTN_DOWN]  = btn_down;
  assign w_raw[BTN_LEFT]  = btn_left;
  assign w_raw[BTN_RIGHT] = btn_right;
  assign w_raw[BTN_SEL]   = btn_sel;

  for (genvar g = 0; g < NUM_BTNS; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .i_btn  (w_raw[g]),
      .o_level(w_level[g]),
      .o_rise (w_rise[g])
    );
  end

`ifdef CURSOR_AUTOREPEAT_EN
  localparam int HOLD_W = $clog2(REPEAT_DELAY + 1);
  localparam logic [HOLD_W-1:0] HOLD_FIRE   = HOLD_W'(REPEAT_DELAY);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(REPEAT_DELAY - REPEAT_PERIOD + 1);

  for (genvar d = 0; d < NUM_DIRS; d++) begin : g_hold
    logic [HOLD_W-1:0] r_hold;

    assign w_repeat[d] = w_level[d] && (r_hold == HOLD_FIRE);

    // Hold timer per direction: zero means idle. An accepted press arms it,
    // it counts while the button stays down, fires first after the initial
    // delay and then every period by reloading, and clears on release. A
    // press swallowed by game_over never arms, so it cannot repeat later.
    always_ff @(posedge clk) begin
      if (rst) begin
        r_hold <= '0;
      end else if (!w_level[d]) begin
        r_hold <= '0;
      end else if (w_rise[d]) begin
        r_hold <= game_over ? '0 : HOLD_W'(1);
      end else if (w_repeat[d]) begin
        r_hold <= HOLD_RELOAD;
      end else if (r_hold != '0) begin
        r_hold <= r_hold + 1'b1;
      end
    end
  end
`else
  assign w_repeat = '0;
`endif

  assign w_move = w_rise[NUM_DIRS-1:0] | w_repeat;

  // Next cursor and press state: both axes step independently (diagonal
  // moves allowed, opposites cancel) and select produces a single pulse;
  // game_over discards all of it.
  always_comb begin
    w_nextX       = r_x;
    w_nextY       = r_y;
    w_nextPressed = 1'b0;
    if (!game_over) begin
      w_nextX       = stepCoord(r_x, w_move[BTN_LEFT], w_move[BTN_RIGHT], BOARD_SIZE);
      w_nextY       = stepCoord(r_y, w_move[BTN_UP], w_move[BTN_DOWN], BOARD_SIZE);
      w_nextPressed = w_rise[BTN_SEL];
    end
  end

  // Registered outputs so the game logic sees clean, glitch-free values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_pressed <= 1'b0;
    end else begin
      r_x       <= w_nextX;
      r_y       <= w_nextY;
      r_pressed <= w_nextPressed;
    end
  end

  assign cursor_x   = r_x;
  assign cursor_y   = r_y;
  assign is_pressed = r_pressed;

endmodule

// File: tb/tb_cursor_ctrl.sv
// Self-checking bench for cursor_ctrl with short debounce/repeat timings.
// A reference model rebuilt from the button rules (raw history, "last N
// synced samples disagree" acceptance, wrap arithmetic) runs alongside the
// DUT; directed vectors and hand-written sequences pin the corner cases.
// Honours CURSOR_AUTOREPEAT_EN when the build defines it.
module tb_cursor_ctrl;
  import chess_pkg::*;

  localparam int DEB  = 4;
  localparam int RDLY = 8;
  localparam int RPER = 4;
  localparam int BSZ  = 8;

  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] UP   = 5'b00001;
  localparam logic [4:0] DN   = 5'b00010;
  localparam logic [4:0] LF   = 5'b00100;
  localparam logic [4:0] RT   = 5'b01000;
  localparam logic [4:0] SL   = 5'b10000;

  typedef struct {
    logic [4:0] btns;
    logic       gameOver;
    int         holdCycles;
    int         expX;
    int         expY;
    int         expPresses;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic       btn_left = 1'b0;
  logic       btn_right = 1'b0;
  logic       btn_sel = 1'b0;
  logic       game_over = 1'b0;
  logic [3:0] cursor_x;
  logic [3:0] cursor_y;
  logic       is_pressed;

  int checks = 0;
  int failures = 0;
  int pressCount = 0;
  bit checkEn = 1'b0;

  vec_t vecs[10];

  always #5 clk = ~clk;

  cursor_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .BOARD_SIZE     (BSZ),
    .REPEAT_DELAY   (RDLY),
    .REPEAT_PERIOD  (RPER)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_up    (btn_up),
    .btn_down  (btn_down),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_sel   (btn_sel),
    .game_over (game_over),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .is_pressed(is_pressed)
  );

  logic [4:0] rawRing[64];
  int         mEdge;
  logic [4:0] mStable;
  logic [4:0] mStableOld;
  int         mX;
  int         mY;
  logic       mPressed;
  int         armedAt[4];

  // Value the debouncer sees at edge k: raw sampled two edges earlier,
  // zero while that sample predates the last reset.
  function automatic logic [4:0] seenAt(input int k);
    if (k - 2 >= 1) return rawRing[(k - 2) % 64];
    return 5'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] btns, input logic go, input int cycles);
    btn_up    = btns[BTN_UP];
    btn_down  = btns[BTN_DOWN];
    btn_left  = btns[BTN_LEFT];
    btn_right = btns[BTN_RIGHT];
    btn_sel   = btns[BTN_SEL];
    game_over = go;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(NONE, 1'b0, 2);
    rst = 1'b0;
  endtask

  // Reference model, advanced once per clock edge from the same input
  // values the DUT samples.
  always @(posedge clk) begin : refModel
    logic [4:0] raw;
    logic [4:0] ev;
    logic [4:0] mv;
    logic [4:0] s;
    bit         allDiffer;
    raw[BTN_UP]    = btn_up;
    raw[BTN_DOWN]  = btn_down;
    raw[BTN_LEFT]  = btn_left;
    raw[BTN_RIGHT] = btn_right;
    raw[BTN_SEL]   = btn_sel;
    if (rst) begin
      mEdge = 0;
      mStable = 5'b0;
      mStableOld = 5'b0;
      mX = 0;
      mY = 0;
      mPressed = 1'b0;
      for (int d = 0; d < 4; d++) armedAt[d] = -1;
    end else begin
      mEdge++;
      rawRing[mEdge % 64] = raw;
      ev = mStable & ~mStableOld;
      mv = ev;
`ifdef CURSOR_AUTOREPEAT_EN
      for (int d = 0; d < 4; d++) begin
        if (ev[d]) begin
          armedAt[d] = game_over ? -1 : mEdge;
        end else if (mStable[d] && armedAt[d] >= 0 && mEdge - armedAt[d] >= RDLY &&
                     ((mEdge - armedAt[d] - RDLY) % RPER) == 0) begin
          mv[d] = 1'b1;
        end
      end
`endif
      if (!game_over) begin
        mX = (mX + int'(mv[BTN_RIGHT]) - int'(mv[BTN_LEFT]) + BSZ) % BSZ;
        mY = (mY + int'(mv[BTN_DOWN]) - int'(mv[BTN_UP]) + BSZ) % BSZ;
      end
      mPressed = ev[BTN_SEL] && !game_over;
      mStableOld = mStable;
      for (int b = 0; b < 5; b++) begin
        allDiffer = 1'b1;
        for (int k = mEdge - DEB + 1; k <= mEdge; k++) begin
          s = seenAt(k);
          if (s[b] == mStable[b]) allDiffer = 1'b0;
        end
        if (allDiffer) mStable[b] = ~mStable[b];
      end
    end
  end

  // Every cycle, compare the DUT against the model and tally select pulses.
  always @(negedge clk) begin
    if (is_pressed === 1'b1) pressCount++;
    if (checkEn) begin
      checkOutput("modelX", 32'(cursor_x), 32'(mX));
      checkOutput("modelY", 32'(cursor_y), 32'(mY));
      checkOutput("modelPress", 32'(is_pressed), 32'(mPressed));
    end
  end

  initial begin
    int pressBase;
    vecs[0] = '{UP,      1'b0, 6, 0, 7, 0};
    vecs[1] = '{LF,      1'b0, 6, 7, 7, 0};
    vecs[2] = '{RT,      1'b0, 6, 0, 7, 0};
    vecs[3] = '{UP | DN, 1'b0, 6, 0, 7, 0};
    vecs[4] = '{DN | RT, 1'b0, 6, 1, 0, 0};
    vecs[5] = '{SL,      1'b0, 6, 1, 0, 1};
    vecs[6] = '{LF | RT | UP, 1'b0, 6, 1, 7, 1};
    vecs[7] = '{SL | LF, 1'b0, 6, 0, 7, 2};
    vecs[8] = '{RT | DN, 1'b1, 8, 0, 7, 2};
    vecs[9] = '{DN,      1'b0, 2, 0, 7, 2};

    repeat (2) @(negedge clk);
    checkEn = 1'b1;
    checkOutput("resetX", 32'(cursor_x), 0);
    checkOutput("resetY", 32'(cursor_y), 0);
    checkOutput("resetPress", 32'(is_pressed), 0);
    rst = 1'b0;

    // Press latency: first move exactly seven edges after the raw press.
    btn_right = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checkOutput("rightLatencyX", 32'(cursor_x), (i >= 7) ? 1 : 0);
      checkOutput("rightNoPress", 32'(is_pressed), 0);
    end
    applyStimulus(NONE, 1'b0, 12);
`ifdef CURSOR_AUTOREPEAT_EN
    checkOutput("rightHeldX", 32'(cursor_x), 2);
`else
    checkOutput("rightHeldX", 32'(cursor_x), 1);
`endif

    // Reset in the middle of a debounce must restart the count.
    doReset();
    applyStimulus(UP, 1'b0, 4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checkOutput("resetMidDebounceY", 32'(cursor_y), (i >= 7) ? 7 : 0);
    end
    applyStimulus(NONE, 1'b0, 12);

    // A glitch shorter than the debounce window does nothing.
    doReset();
    applyStimulus(DN, 1'b0, 3);
    applyStimulus(NONE, 1'b0, 12);
    checkOutput("glitchY", 32'(cursor_y), 0);
    checkOutput("glitchX", 32'(cursor_x), 0);

    // Directed vector table from a fresh reset.
    doReset();
    pressBase = pressCount;
    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].btns, vecs[v].gameOver, vecs[v].holdCycles);
      applyStimulus(NONE, 1'b0, 12);
      checkOutput($sformatf("vec%0dX", v), 32'(cursor_x), 32'(vecs[v].expX));
      checkOutput($sformatf("vec%0dY", v), 32'(cursor_y), 32'(vecs[v].expY));
      checkOutput($sformatf("vec%0dPresses", v), 32'(pressCount - pressBase),
                  32'(vecs[v].expPresses));
    end

    // Bouncing select followed by a clean hold: one pulse, seven edges in.
    doReset();
    for (int i = 0; i < 8; i++) applyStimulus((i % 2 == 0) ? SL : NONE, 1'b0, 1);
    btn_sel = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checkOutput("selBouncePulse", 32'(is_pressed), (i == 7) ? 1 : 0);
    end
    applyStimulus(NONE, 1'b0, 12);

    // game_over swallows presses; a button held across its fall stays dead
    // until it is released and pressed again.
    doReset();
    applyStimulus(SL | DN, 1'b1, 0);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      checkOutput("gameOverPress", 32'(is_pressed), 0);
      checkOutput("gameOverY", 32'(cursor_y), 0);
    end
    applyStimulus(DN, 1'b0, 0);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      checkOutput("heldAfterGameOverY", 32'(cursor_y), 0);
    end
    applyStimulus(NONE, 1'b0, 12);
    checkOutput("releasedY", 32'(cursor_y), 0);
    applyStimulus(DN, 1'b0, 6);
    applyStimulus(NONE, 1'b0, 12);
    checkOutput("repressY", 32'(cursor_y), 1);

    // Long hold of a direction button.
    doReset();
    applyStimulus(RT, 1'b0, 30);
`ifdef CURSOR_AUTOREPEAT_EN
    checkOutput("longHoldX", 32'(cursor_x), 5);
`else
    checkOutput("longHoldX", 32'(cursor_x), 1);
`endif
    applyStimulus(NONE, 1'b0, 12);

    // Randomised button traffic, checked every cycle against the model.
    doReset();
    for (int it = 0; it < 200; it++) begin
      applyStimulus(5'($urandom_range(0, 31)), ($urandom_range(0, 7) == 0),
                    $urandom_range(1, 14));
    end
    applyStimulus(NONE, 1'b0, 12);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
